noc_buf_ctrl: RTL

- Synchronous FIFO controller that sits directly upstream of the ram_8x32 storage in each router input buffer.
- Accepts flits from the link on a valid/ready interface and generates all RAM write-port and read-port controls.
- Presents the oldest stored flit to the route/arbitration stage on a first-word-fall-through valid/ready interface.
- The RAM's wr_clk and rd_clk are both tied to clk outside this block. The RAM's rst_n is driven from ~rst.

---
 rtl/noc_buf_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/noc_buf_ctrl.sv
// Router input-buffer FIFO controller: drives an external 1-cycle-latency RAM
// and presents the oldest flit first-word-fall-through on a valid/ready port.
module noc_buf_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  afull
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AFULL_C = AFULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic                  out_vld;
  logic                  push;
  logic                  issue;
  logic                  pop;

  // Handshake decode uses the pre-edge count, so an issue can never read the
  // slot being written in the same cycle and a full buffer never passes through.
  always_comb begin
    in_ready = !rst && (mem_cnt != DEPTH_C);
    push     = in_valid && in_ready;
    pop      = out_vld && out_ready;
    issue    = !rst && (mem_cnt != '0) && (!out_vld || out_ready);
  end

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = in_data;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = rd_ptr;

  assign out_valid = out_vld;
  assign out_data  = ram_rd_data;
  assign occupancy = mem_cnt + {{ADDR_WIDTH{1'b0}}, out_vld};
  assign afull     = (occupancy >= AFULL_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      out_vld <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   mem_cnt <= mem_cnt + ONE_C;
        2'b01:   mem_cnt <= mem_cnt - ONE_C;
        default: mem_cnt <= mem_cnt;
      endcase
      if (issue)    out_vld <= 1'b1;
      else if (pop) out_vld <= 1'b0;
    end
  end

endmodule
